norm_unit: RTL
==============

NORM_UNIT -- requirements
Module: norm_unit

Interface
REQ-001 Parameter: WIDTH, default 8, data and shift-amount width in bits (minimum 2).
REQ-002 Port: clk_i  input  1  sole clock; all state updates on rising edge.
REQ-003 Port: rst_ni  input  1  reset, asynchronous, active-low.
REQ-004 Port: start_i  input  1  request; sampled only in IDLE.
REQ-005 Port: dir_i  input  1  0 = normalize left (until MSB=1), 1 = normalize right (until LSB=1); captured with start.
REQ-006 Port: A_i  input  WIDTH  operand; captured with start.
REQ-007 Port: data_o  output  WIDTH  normalized operand.
REQ-008 Port: shamt_o  output  WIDTH  number of single-bit shifts applied; feeding it back to the shifter in the opposite direction restores A_i.
REQ-009 Port: busy_o  output  1  high in SHIFT and DONE.
REQ-010 Port: done_o  output  1  one-cycle completion pulse.
REQ-011 Port: zero_o  output  1  operand was all zeros.

Function
REQ-012 The FSM SHALL have states IDLE, SHIFT and DONE.
- IDLE -> SHIFT when start_i=1: load A_i, dir_i, count=0, zero_o=0.
- IDLE, start_i=0: hold.
REQ-013 In SHIFT, each edge SHALL:
- operand == 0: set zero_o=1, count=0, go to DONE;
- else target bit (MSB if dir=0, LSB if dir=1) == 1: go to DONE;
- else: logical shift by one toward the target (vacated bit = 0), count+1.
REQ-014 Count SHALL never exceed WIDTH-1; no wrap.
REQ-015 DONE SHALL assert done_o for exactly one cycle, then go to IDLE.
REQ-016 Latency: start sampled at edge E0 with k positions to normalize SHALL give done_o high from edge E0+k+1 to E0+k+2; all-zero operand gives k=0.
REQ-017 data_o and shamt_o SHALL show the working register and count continuously.
- Valid when done_o=1.
- Held through IDLE until the next start is accepted.
REQ-018 start_i in SHIFT or DONE SHALL be ignored (not queued).
REQ-019 busy_o SHALL equal (state != IDLE); done_o SHALL equal (state == DONE).
REQ-020 A start accepted in the IDLE cycle right after DONE SHALL work normally (back-to-back operation).

Reset
REQ-021 rst_ni=0 SHALL immediately and asynchronously force:
- state IDLE;
- data_o=0, shamt_o=0, busy_o=0, done_o=0, zero_o=0.
REQ-022 Reset during SHIFT or DONE SHALL abandon the operation; no done_o pulse follows.
REQ-023 After rst_ni deasserts, the first start SHALL be accepted on the first rising edge.

Configuration
REQ-024 Macro NORM_ABORT_EN:
- Defined: adds port abort_i (input, 1) with priority over all SHIFT/DONE transitions. When high at an edge in SHIFT or DONE, the FSM returns to IDLE, no done_o pulse, data_o/shamt_o hold their current values.
- Undefined: no abort_i port, and the behaviour is exactly REQ-012..REQ-020.

Verification
REQ-025 WIDTH=8, A_i=0x10, dir_i=0, start -> done_o 4 cycles after start edge; data_o=0x80, shamt_o=3, zero_o=0.
REQ-026 A_i=0x80, dir_i=0 -> done_o after 1 cycle; data_o=0x80, shamt_o=0. Also A_i=0x01, dir_i=0 -> data_o=0x80, shamt_o=7, done_o after 8 cycles.
REQ-027 A_i=0x00 (either dir_i) -> done_o after 1 cycle; zero_o=1, data_o=0x00, shamt_o=0.
REQ-028 A_i=0x28, dir_i=1 -> data_o=0x05, shamt_o=3. Second start (A_i=0xFF) pulsed while busy_o=1 -> ignored, result unchanged.
REQ-029 A_i=0x01, dir_i=0, rst_ni=0 for 1 cycle at third SHIFT cycle -> all outputs 0 immediately, no done_o. The next start is serviced normally.
REQ-030 With NORM_ABORT_EN: A_i=0x02, dir_i=0, abort_i=1 on second SHIFT edge -> busy_o=0 next cycle, no done_o, shamt_o=1 held.

Source files
------------

// File: rtl/norm_unit.sv
// norm_unit: iterative single-bit normalizer.
// Shifts a captured operand one position per cycle toward its MSB (dir_i=0)
// or LSB (dir_i=1) until that bit is set, counting the shifts applied.
// Optional feature: define NORM_ABORT_EN to add an abort_i port that returns
// the FSM to IDLE from SHIFT or DONE without a done_o pulse.
module norm_unit #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
`ifdef NORM_ABORT_EN
  input  logic             abort_i,
`endif
  input  logic             start_i,
  input  logic             dir_i,
  input  logic [WIDTH-1:0] A_i,
  output logic [WIDTH-1:0] data_o,
  output logic [WIDTH-1:0] shamt_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             zero_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   data_q,  data_d;
  logic [WIDTH-1:0]   shamt_q, shamt_d;
  logic               dir_q,   dir_d;
  logic               zero_q,  zero_d;
  logic               busy_q,  busy_d;
  logic               done_q,  done_d;
  logic               target_bit;

  // Bit that must be set for the operand to count as normalized.
  assign target_bit = dir_q ? data_q[0] : data_q[WIDTH-1];

  // Next-state and datapath update for the normalize sequence.
  always_comb begin
    // NOTE: every variable gets a hold default first so no path leaves it
    // unassigned; otherwise synthesis would infer a latch.
    state_d = state_q;
    data_d  = data_q;
    shamt_d = shamt_q;
    dir_d   = dir_q;
    zero_d  = zero_q;

    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          data_d  = A_i;
          dir_d   = dir_i;
          shamt_d = '0;
          zero_d  = 1'b0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (data_q == '0) begin
          zero_d  = 1'b1;
          shamt_d = '0;
          state_d = DONE;
        end else if (target_bit) begin
          state_d = DONE;
        end else begin
          // A nonzero operand reaches its target in at most WIDTH-1 shifts,
          // so the count cannot overflow.
          data_d  = dir_q ? {1'b0, data_q[WIDTH-1:1]} : {data_q[WIDTH-2:0], 1'b0};
          shamt_d = shamt_q + WIDTH'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

`ifdef NORM_ABORT_EN
    // Abort overrides everything in SHIFT/DONE and freezes the visible results.
    if (abort_i && (state_q != IDLE)) begin
      state_d = IDLE;
      data_d  = data_q;
      shamt_d = shamt_q;
      zero_d  = zero_q;
    end
`endif

    // Status outputs are registered copies decoded from the next state.
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    // NOTE: sequential state uses non-blocking assignments so all flops
    // update together from the values present before the edge.
    if (!rst_ni) begin
      state_q <= IDLE;
      data_q  <= '0;
      shamt_q <= '0;
      dir_q   <= 1'b0;
      zero_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      shamt_q <= shamt_d;
      dir_q   <= dir_d;
      zero_q  <= zero_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign data_o  = data_q;
  assign shamt_o = shamt_q;
  assign busy_o  = busy_q;
  assign done_o  = done_q;
  assign zero_o  = zero_q;

endmodule
